// File: rtl/hdmi_pkg.sv
// hdmi_pkg: shared display constants, scale-shift type and pixel-packing helpers
// for the HDMI pixel path.
package hdmi_pkg;

  localparam int H_ACTIVE_DEF = 1280;
  localparam int V_ACTIVE_DEF = 720;

  typedef logic [1:0] scale_t;

  localparam int     RST_BASE  = 0;
  localparam scale_t RST_SCALE = 2'd2;

  function automatic int ppw(input int word_w, input int pix_w);
    return word_w / pix_w;
  endfunction

  function automatic int ppw_log2(input int word_w, input int pix_w);
    return $clog2(ppw(word_w, pix_w));
  endfunction

  // Lane index needs at least one bit even when a word holds a single pixel.
  function automatic int lane_w(input int word_w, input int pix_w);
    return (ppw(word_w, pix_w) > 1) ? ppw_log2(word_w, pix_w) : 1;
  endfunction

  // Default stride matches the legacy quarter-scale layout.
  function automatic int rst_stride(input int h_active, input int word_w, input int pix_w);
    return (h_active >> 2) / ppw(word_w, pix_w);
  endfunction

endpackage

// File: rtl/hdmi_pixfetch_unpack.sv
// hdmi_pixfetch_unpack: VRAM word hold register and pixel lane multiplexer.
module hdmi_pixfetch_unpack
  import hdmi_pkg::*;
#(
  parameter int PIX_W  = 8,
  parameter int WORD_W = 32,
  parameter int LANE_W = lane_w(WORD_W, PIX_W)
) (
  input  logic              clk_pix,
  input  logic              rst_n,
  input  logic              re_p1,
  input  logic [WORD_W-1:0] rdata,
  input  logic [LANE_W-1:0] lane_p2,
  output logic [PIX_W-1:0]  lane_pix
);

  logic [WORD_W-1:0] hold_p2;

  // Stage 2: a fresh word is captured only when a read was issued; otherwise the held word is reused.
  always_ff @(posedge clk_pix) begin
    if (!rst_n) begin
      hold_p2 <= '0;
    end else if (re_p1) begin
      hold_p2 <= rdata;
    end
  end

  assign lane_pix = hold_p2[int'(lane_p2)*PIX_W +: PIX_W];

endmodule

// File: rtl/hdmi_pixfetch.sv
// hdmi_pixfetch: VRAM-to-pixel fetch engine with runtime downscale and frame-shadowed config.
// Optional test-pattern generator is built when HDMI_PIXFETCH_TESTPAT_EN is defined.
module hdmi_pixfetch
  import hdmi_pkg::*;
#(
  parameter int H_ACTIVE       = H_ACTIVE_DEF,
  parameter int PIX_W          = 8,
  parameter int WORD_W         = 32,
  parameter int ADDR_W         = 16,
  parameter int MAX_SCALE_LOG2 = 2
) (
  input  logic              clk_pix,
  input  logic              rst_n,
  input  logic              frame_start,
  input  logic              de,
  input  logic [11:0]       h_pos,
  input  logic [11:0]       v_pos,
  input  logic [ADDR_W-1:0] cfg_base,
  input  logic [ADDR_W-1:0] cfg_stride,
  input  logic [1:0]        cfg_scale,
  input  logic              cfg_testpat,
  output logic              vram_re,
  output logic [ADDR_W-1:0] vram_addr,
  input  logic [WORD_W-1:0] vram_rdata,
  output logic [PIX_W-1:0]  pix_data,
  output logic              pix_valid
);

  localparam int PPW      = ppw(WORD_W, PIX_W);
  localparam int PPW_LOG2 = ppw_log2(WORD_W, PIX_W);
  localparam int LANE_W   = lane_w(WORD_W, PIX_W);
  localparam logic [ADDR_W-1:0] RST_STRIDE = ADDR_W'(rst_stride(H_ACTIVE, WORD_W, PIX_W));

  function automatic scale_t clamp_scale(input scale_t s);
    return (int'(s) > MAX_SCALE_LOG2) ? scale_t'(MAX_SCALE_LOG2) : s;
  endfunction

  logic [ADDR_W-1:0] stride_q, row_base, vram_addr_p0;
  scale_t            scale_q;
  logic              armed, de_act, de_d, row_end, tp_on, re_c;
  logic [11:0]       v_last, smask, sx, word_x, wx_prev;
  logic [LANE_W-1:0] lane_c, lane_p0, lane_p1, lane_p2;
  logic              vram_re_p0, re_p1;
  logic              vld_p0, vld_p1, vld_p2, vld_p3;
  logic [PIX_W-1:0]  lane_pix, pix_sel, pix_p3;

  // Nothing is fetched after reset until a frame_start re-establishes the frame origin.
  assign de_act  = de & armed;
  assign sx      = h_pos >> scale_q;
  assign word_x  = sx >> PPW_LOG2;
  assign lane_c  = LANE_W'(sx & 12'(PPW - 1));
  assign smask   = (12'd1 << scale_q) - 12'd1;
  assign row_end = (v_last & smask) == smask;
  assign re_c    = de_act & (~de_d | (word_x != wx_prev)) & ~tp_on;

  always_ff @(posedge clk_pix) begin
    if (!rst_n) begin
      stride_q <= RST_STRIDE;
      scale_q  <= clamp_scale(RST_SCALE);
      row_base <= ADDR_W'(RST_BASE);
      armed    <= 1'b0;
      de_d     <= 1'b0;
    end else begin
      de_d <= de_act;
      if (frame_start) begin
        stride_q <= cfg_stride;
        scale_q  <= clamp_scale(cfg_scale);
        row_base <= cfg_base;
        armed    <= 1'b1;
      end else if (de_d && !de_act && row_end) begin
        row_base <= row_base + stride_q;
      end
    end
  end

  always_ff @(posedge clk_pix) begin
    if (de_act) v_last <= v_pos;
    wx_prev <= word_x;
  end

`ifdef HDMI_PIXFETCH_TESTPAT_EN
  logic             tp_q, tp_p0, tp_p1, tp_p2;
  logic [11:0]      sy;
  logic [23:0]      line_w;
  logic [PIX_W-1:0] pat_c, pat_p0, pat_p1, pat_p2;

  assign sy     = v_pos >> scale_q;
  assign line_w = 24'(H_ACTIVE) >> scale_q;
  assign pat_c  = PIX_W'(24'(sx) + 24'(sy) * line_w);
  assign tp_on  = tp_q;

  always_ff @(posedge clk_pix) begin
    if (!rst_n) begin
      tp_q <= 1'b0;
    end else if (frame_start) begin
      tp_q <= cfg_testpat;
    end
  end

  // Pattern rides the same three stages as VRAM data so latency is identical.
  always_ff @(posedge clk_pix) begin
    tp_p0  <= tp_q;
    tp_p1  <= tp_p0;
    tp_p2  <= tp_p1;
    pat_p0 <= pat_c;
    pat_p1 <= pat_p0;
    pat_p2 <= pat_p1;
  end

  assign pix_sel = tp_p2 ? pat_p2 : lane_pix;
`else
  logic unused_testpat;
  assign unused_testpat = cfg_testpat;
  assign tp_on          = 1'b0;
  assign pix_sel        = lane_pix;
`endif

  // Stage 1: address generation and read suppression.
  always_ff @(posedge clk_pix) begin
    if (!rst_n) begin
      vram_re_p0   <= 1'b0;
      vram_addr_p0 <= '0;
      vld_p0       <= 1'b0;
    end else begin
      vram_re_p0   <= re_c;
      vram_addr_p0 <= row_base + ADDR_W'(word_x);
      vld_p0       <= de_act;
    end
  end

  always_ff @(posedge clk_pix) begin
    lane_p0 <= lane_c;
    lane_p1 <= lane_p0;
    lane_p2 <= lane_p1;
  end

  // Stage 2: read data arrives; the unpacker holds it for the rest of the word.
  always_ff @(posedge clk_pix) begin
    if (!rst_n) begin
      re_p1  <= 1'b0;
      vld_p1 <= 1'b0;
      vld_p2 <= 1'b0;
    end else begin
      re_p1  <= vram_re_p0;
      vld_p1 <= vld_p0;
      vld_p2 <= vld_p1;
    end
  end

  hdmi_pixfetch_unpack #(
    .PIX_W  (PIX_W),
    .WORD_W (WORD_W),
    .LANE_W (LANE_W)
  ) u_unpack (
    .clk_pix  (clk_pix),
    .rst_n    (rst_n),
    .re_p1    (re_p1),
    .rdata    (vram_rdata),
    .lane_p2  (lane_p2),
    .lane_pix (lane_pix)
  );

  // Stage 3: output register, blanked outside active video.
  always_ff @(posedge clk_pix) begin
    if (!rst_n) begin
      pix_p3 <= '0;
      vld_p3 <= 1'b0;
    end else begin
      vld_p3 <= vld_p2;
      pix_p3 <= vld_p2 ? pix_sel : '0;
    end
  end

  assign vram_re   = vram_re_p0;
  assign vram_addr = vram_addr_p0;
  assign pix_data  = pix_p3;
  assign pix_valid = vld_p3;

endmodule

// File: tb/tb_hdmi_pixfetch.sv
// tb_hdmi_pixfetch: directed bench for hdmi_pixfetch with a synchronous VRAM model
// and a per-pixel expected-value pipeline.
module tb_hdmi_pixfetch;

  logic        clk_pix = 1'b0;
  logic        rst_n, frame_start, de, cfg_testpat;
  logic [11:0] h_pos, v_pos;
  logic [15:0] cfg_base, cfg_stride;
  logic [1:0]  cfg_scale;
  logic        vram_re;
  logic [15:0] vram_addr;
  logic [31:0] vram_rdata;
  logic [7:0]  pix_data;
  logic        pix_valid;

  int errors = 0;
  int checks = 0;

  // Reference model state
  logic [15:0] m_base, m_stride;
  int          m_s;
  logic        m_tp, m_armed;
  logic        q_vld[$];
  logic [7:0]  q_pix[$];
  int          q_h[$], q_v[$];
  int          probe_h = -1, probe_v = -1;
  logic [7:0]  probe_val;
  int          re_cnt, first_h, second_h;
  logic [15:0] first_addr, last_addr;

  always #5 clk_pix = ~clk_pix;

  hdmi_pixfetch dut (
    .clk_pix     (clk_pix),
    .rst_n       (rst_n),
    .frame_start (frame_start),
    .de          (de),
    .h_pos       (h_pos),
    .v_pos       (v_pos),
    .cfg_base    (cfg_base),
    .cfg_stride  (cfg_stride),
    .cfg_scale   (cfg_scale),
    .cfg_testpat (cfg_testpat),
    .vram_re     (vram_re),
    .vram_addr   (vram_addr),
    .vram_rdata  (vram_rdata),
    .pix_data    (pix_data),
    .pix_valid   (pix_valid)
  );

  // Each lane of word a carries a distinct value so lane selection is visible.
  function automatic logic [31:0] vword(input logic [15:0] a);
    return {a[7:0] + 8'd3, a[7:0] + 8'd2, a[7:0] + 8'd1, a[7:0]};
  endfunction

  always @(posedge clk_pix) vram_rdata <= vram_re ? vword(vram_addr) : 32'hDEAD_BEEF;

  function automatic logic [7:0] exp_pix(input int h, input int v);
    int sx, sy;
    logic [15:0] row, a;
    logic [31:0] w, p;
    sx = h >> m_s;
    sy = v >> m_s;
    if (m_tp) begin
      p = 32'(sx + sy * (1280 >> m_s));
      return p[7:0];
    end
    row = m_base + 16'((v >> m_s) * int'(m_stride));
    a   = row + 16'(sx >> 2);
    w   = vword(a);
    return w[(sx % 4) * 8 +: 8];
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step(input logic d, input int h, input int v, input logic fs);
    logic       ev;
    logic [7:0] ep;
    int         eh, evv;
    de = d; h_pos = 12'(h); v_pos = 12'(v); frame_start = fs;
    q_vld.push_back(d && m_armed);
    q_pix.push_back((d && m_armed) ? exp_pix(h, v) : 8'h00);
    q_h.push_back(h);
    q_v.push_back(v);
    if (fs) begin
      m_base   = cfg_base;
      m_stride = cfg_stride;
      m_s      = (cfg_scale > 2'd2) ? 2 : int'(cfg_scale);
`ifdef HDMI_PIXFETCH_TESTPAT_EN
      m_tp     = cfg_testpat;
`else
      m_tp     = 1'b0;
`endif
      m_armed  = 1'b1;
    end
    @(posedge clk_pix); #1;
    if (vram_re) begin
      re_cnt++;
      if (re_cnt == 1) begin first_addr = vram_addr; first_h = h; end
      else if (re_cnt == 2) second_h = h;
      last_addr = vram_addr;
    end
    if (q_vld.size() == 4) begin
      ev  = q_vld.pop_front();
      ep  = q_pix.pop_front();
      eh  = q_h.pop_front();
      evv = q_v.pop_front();
      chk("pix_valid", 32'(pix_valid), 32'(ev));
      chk("pix_data", 32'(pix_data), 32'(ep));
      if (ev && eh == probe_h && evv == probe_v) chk("probe_pix", 32'(pix_data), 32'(probe_val));
    end
  endtask

  task automatic blank(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 0, 0, 1'b0);
  endtask

  task automatic frame();
    step(1'b0, 0, 0, 1'b1);
    blank(2);
  endtask

  task automatic drive_line(input int v, input int nh);
    re_cnt = 0; first_h = -1; second_h = -1;
    for (int h = 0; h < nh; h++) step(1'b1, h, v, 1'b0);
    blank(4);
  endtask

  task automatic set_cfg(input logic [15:0] b, input logic [15:0] st, input logic [1:0] s,
                         input logic tp);
    cfg_base = b; cfg_stride = st; cfg_scale = s; cfg_testpat = tp;
  endtask

  initial begin
    rst_n = 1'b0; de = 1'b0; frame_start = 1'b0; h_pos = '0; v_pos = '0;
    set_cfg(16'h0000, 16'd80, 2'd2, 1'b0);
    m_base = 0; m_stride = 80; m_s = 2; m_tp = 0; m_armed = 0;

    // Reset state
    repeat (3) @(posedge clk_pix);
    #1;
    chk("rst_vram_re", 32'(vram_re), 0);
    chk("rst_vram_addr", 32'(vram_addr), 0);
    chk("rst_pix_data", 32'(pix_data), 0);
    chk("rst_pix_valid", 32'(pix_valid), 0);
    rst_n = 1'b1;

    // Legacy quarter-scale frame
    frame();
    for (int v = 0; v < 8; v++) begin
      drive_line(v, 64);
      chk("legacy_reads", re_cnt, 4);
      chk("legacy_first_addr", 32'(first_addr), (v < 4) ? 0 : 80);
      chk("legacy_first_h", first_h, 0);
    end

    // Shadowing: mid-frame config change takes effect only at next frame_start
    frame();
    drive_line(0, 64);
    set_cfg(16'h0100, 16'd16, 2'd0, 1'b0);
    for (int v = 1; v < 4; v++) drive_line(v, 64);
    chk("shadow_old_reads", re_cnt, 4);
    chk("shadow_old_addr", 32'(first_addr), 0);
    frame();
    drive_line(0, 64);
    chk("shadow_first_addr", 32'(first_addr), 32'h100);
    chk("shadow_second_h", second_h, 4);
    chk("shadow_reads", re_cnt, 16);
    drive_line(1, 64);
    chk("shadow_line1_addr", 32'(first_addr), 32'h110);

    // Row advance at s=1, stride 160
    set_cfg(16'h0000, 16'd160, 2'd1, 1'b0);
    frame();
    for (int v = 0; v < 4; v++) begin
      drive_line(v, 64);
      chk("row_first_addr", 32'(first_addr), (v < 2) ? 0 : 160);
      chk("row_reads", re_cnt, 8);
    end

    // Address wrap
    set_cfg(16'hFFF0, 16'd16, 2'd0, 1'b0);
    frame();
    drive_line(0, 80);
    chk("wrap_first_addr", 32'(first_addr), 32'hFFF0);
    chk("wrap_last_addr", 32'(last_addr), 32'h0003);
    chk("wrap_reads", re_cnt, 20);
    drive_line(1, 16);
    chk("wrap_row_addr", 32'(first_addr), 32'h0000);

    // Latency and mid-line reset
    set_cfg(16'h0000, 16'd80, 2'd2, 1'b0);
    frame();
    step(1'b1, 0, 0, 1'b0); chk("lat_k0", 32'(pix_valid), 0);
    step(1'b1, 1, 0, 1'b0); chk("lat_k1", 32'(pix_valid), 0);
    step(1'b1, 2, 0, 1'b0); chk("lat_k2", 32'(pix_valid), 0);
    step(1'b1, 3, 0, 1'b0); chk("lat_k3", 32'(pix_valid), 1);
    step(1'b1, 4, 0, 1'b0);
    rst_n = 1'b0; h_pos = 12'd5;
    @(posedge clk_pix); #1;
    chk("midrst_vram_re", 32'(vram_re), 0);
    chk("midrst_vram_addr", 32'(vram_addr), 0);
    chk("midrst_pix_data", 32'(pix_data), 0);
    chk("midrst_pix_valid", 32'(pix_valid), 0);
    q_vld.delete(); q_pix.delete(); q_h.delete(); q_v.delete();
    m_armed = 1'b0;
    rst_n = 1'b1;
    re_cnt = 0;
    for (int i = 0; i < 10; i++) step(1'b1, 6 + i, 0, 1'b0);
    blank(4);
    chk("midrst_no_reads", re_cnt, 0);
    frame();
    for (int v = 0; v < 2; v++) drive_line(v, 64);
    chk("postrst_reads", re_cnt, 4);

    // Test pattern (ignored in the default build)
    set_cfg(16'h0000, 16'd80, 2'd2, 1'b1);
    probe_h = 8; probe_v = 4;
`ifdef HDMI_PIXFETCH_TESTPAT_EN
    probe_val = 8'h42;
`else
    probe_val = 8'h52;
`endif
    frame();
    for (int v = 0; v < 5; v++) drive_line(v, 16);
`ifdef HDMI_PIXFETCH_TESTPAT_EN
    chk("tp_reads", re_cnt, 0);
`else
    chk("tp_reads", re_cnt, 1);
`endif
    probe_h = -1; probe_v = -1;

    // Scale clamp: 3 behaves as 2
    set_cfg(16'h0000, 16'd80, 2'd3, 1'b0);
    frame();
    for (int v = 0; v < 5; v++) drive_line(v, 64);
    chk("clamp_reads", re_cnt, 4);
    chk("clamp_first_addr", 32'(first_addr), 80);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/hdmi_pixfetch.md
# hdmi_pixfetch

Parametrised VRAM-to-pixel fetch engine, the next generation of the fixed 1/4-scale 8-bit path between `hdmi_vram` and `u_hdmi` inside `top_hdmicontroller`. From the timing generator's `de`/`h_pos`/`v_pos`, it generates synchronous VRAM read addresses and unpacks packed words into pixels. It supports:
- runtime-selectable integer downscale;
- base address and stride, double-buffered at frame boundaries;
- read suppression, so each VRAM word is fetched once per scaled line.

## Interface
Parameters:
- `H_ACTIVE`, 1280: active pixels per line.
- `PIX_W`, 8: bits per pixel; `WORD_W/PIX_W` is a power of two.
- `WORD_W`, 32: VRAM word width.
- `ADDR_W`, 16: VRAM word-address width.
- `MAX_SCALE_LOG2`, 2: largest supported scale shift.

Ports:
- `clk_pix` input 1: pixel clock. This is the only clock.
- `rst_n` input 1: reset, synchronous and active-low.
- `frame_start` input 1: one-cycle pulse, outside `de`, before the first active line.
- `de` input 1: active-video enable.
- `h_pos` input 12: active-region column, valid while `de`.
- `v_pos` input 12: active-region row, valid while `de`.
- `cfg_base` input ADDR_W: frame base word address (shadowed).
- `cfg_stride` input ADDR_W: words per scaled row (shadowed).
- `cfg_scale` input 2: scale shift s (shadowed).
- `cfg_testpat` input 1: test-pattern select (shadowed).
- `vram_re` output 1: VRAM read enable.
- `vram_addr` output ADDR_W: VRAM word address.
- `vram_rdata` input WORD_W: read data, valid in the cycle after `vram_re`.
- `pix_data` output PIX_W: pixel value.
- `pix_valid` output 1: `de`, delayed by the pipeline latency.

## Operation
- **Derived values:**
  - PPW = WORD_W/PIX_W.
  - sx = h_pos>>s, sy = v_pos>>s.
  - word_x = sx/PPW.
  - lane = sx mod PPW. Lane 0 is the least significant PIX_W bits.
- **Shadow registers:**
  - Active copies of base, stride, s and testpat load from the `cfg_*` inputs only on `frame_start`.
  - Reset values: base 0, stride (H_ACTIVE>>2)/PPW, s=2, testpat 0. This reproduces the legacy 1/4 mode.
  - `cfg_scale` > MAX_SCALE_LOG2 clamps to MAX_SCALE_LOG2.
- **Row base register:**
  - Set to base on `frame_start`.
  - On the falling edge of `de`, if v_pos[s-1:0] is all ones (always when s=0), row_base += stride.
  - Addition is modulo 2^ADDR_W.
- **Stage 1:**
  - vram_addr = row_base + word_x, modulo 2^ADDR_W.
  - vram_re = `de` AND (first `de` cycle of the line OR word_x ≠ previous word_x).
  - lane and de are registered alongside.
- **Stage 2:**
  - If re was asserted in the previous cycle, the word is `vram_rdata`, and it is captured into the hold register.
  - Otherwise the held word is used.
- **Stage 3:**
  - pix_data = selected lane, registered.
  - pix_valid = de, registered.
  - pix_data = 0 whenever pix_valid = 0.
- **Read counts:** no VRAM read occurs outside `de`. Reads per line = ceil(H_ACTIVE/(PPW·2^s)).

## Timing
- Latency is 3 cycles: inputs sampled at edge k produce pix_data and pix_valid after edge k+3. The timing generator compensates.
- `vram_re` and `vram_addr` update 1 cycle after the input sample.
- **Reset values:** vram_re=0, vram_addr=0, pix_data=0, pix_valid=0. Shadow registers, row_base and the hold register return to their reset defaults. Reset mid-frame clears the pipeline in one edge, and the first valid frame starts at the next `frame_start`.
- **`frame_start` coincident with `de`:** this is a protocol violation. The current pixel uses the old shadow values, and the new values apply from the next cycle.
- **Address wrap:** row_base + word_x past 2^ADDR_W-1 wraps to 0 silently.

## Configuration
- Macro `HDMI_PIXFETCH_TESTPAT_EN`.
- **Defined, with active testpat=1:**
  - pix_data = (sx + sy·(H_ACTIVE>>s))[PIX_W-1:0].
  - Pipeline latency is unchanged.
  - vram_re is held at 0.
- **Undefined:**
  - `cfg_testpat` is ignored.
  - Only VRAM data is output.
  - No test-pattern logic is generated.

## Structure
- **Shared package `hdmi_pkg`:**
  - H_ACTIVE and V_ACTIVE defaults.
  - Scale-shift type.
  - PPW and lane-width helper functions.
  - Reset-default constants for base, stride and scale.
- **Sub-module `hdmi_pixfetch_unpack`:** word hold register plus lane multiplexer (stage 2/3), parametrised by PIX_W and WORD_W.

## Test plan
1. **Legacy 1/4 mode.** Defaults (PIX_W=8, s=2), VRAM[i] = i.
   - pix_data at (h,v) = ((h/4 + (v/4)·320)/4-word lane) matches the model across one full frame.
   - vram_re pulses once per 16 pixels.
2. **Shadowing.** Change `cfg_scale` to 0 and `cfg_base` to 0x100 mid-frame.
   - Output is unchanged until the next `frame_start`.
   - From then on, the first address is 0x100, and the next read follows 4 pixels later.
3. **Row advance with s=1, stride=160.**
   - Lines 0 and 1 start at addr 0.
   - Lines 2 and 3 start at 160.
   - Address 0xFFF0 plus an offset wraps to 0x0000+.
4. **Latency and reset.**
   - `de` rising at edge k gives pix_valid at edge k+3.
   - rst_n=0 mid-line gives all outputs 0 at the next edge, and no vram_re until `frame_start`.
5. **Test pattern.** With `HDMI_PIXFETCH_TESTPAT_EN` defined and testpat=1, s=2:
   - (h=8, v=4) gives pix_data = (2+320)[7:0] = 0x42.
   - vram_re stays at 0.
6. **Clamp.** cfg_scale=3 with MAX_SCALE_LOG2=2 behaves exactly as s=2.
